router_pkt_tx: RTL and testbench

- Packet source for the router input port. It builds one packet per request: a header byte, then 1–63 payload bytes, then one parity byte.
- Drives the same pkt_valid/data byte stream that the router input register and FSM consume.
- Honours the router's busy back-pressure.
- Used as the stimulus engine in system benches and as the host-side transmitter in the integrated design.

---
 rtl/router_pkt_tx.sv | 113 +++++++++++
 tb/tb_router_pkt_tx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_tx.sv
// Router input-port packet transmitter: header {len,dest}, 1..63 payload bytes, XOR parity byte.
// Optional ROUTER_PKT_TX_PARITY_CORRUPT_EN adds a 'corrupt' input that inverts the sent parity byte.
module router_pkt_tx #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 6,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic [LEN_W-1:0]  pay_len,
    input  logic [DATA_W-1:0] pay_in,
    input  logic              busy,
`ifdef ROUTER_PKT_TX_PARITY_CORRUPT_EN
    input  logic              corrupt,
`endif
    output logic              ready,
    output logic              pay_rd,
    output logic              pkt_valid,
    output logic [DATA_W-1:0] dout,
    output logic              done,
    output logic              err
);

    localparam int MAX_DEST = 2;

    typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, PARITY, DONE} state_t;

    state_t            state;
    logic [LEN_W-1:0]  cnt;
    logic [DATA_W-1:0] par;
    logic [DATA_W-1:0] par_out;
    logic [DATA_W-1:0] header;
    logic              start_ok;

    assign header   = DATA_W'({pay_len, dest_addr});
    assign start_ok = (dest_addr <= ADDR_W'(MAX_DEST)) && (pay_len != '0);

    // Pop only when the byte currently on dout is being accepted this edge.
    assign pay_rd = ((state == HEADER) || (state == PAYLOAD)) && (cnt != '0) && !busy;

`ifdef ROUTER_PKT_TX_PARITY_CORRUPT_EN
    logic corrupt_q;
    assign par_out = corrupt_q ? ~par : par;
`else
    assign par_out = par;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            par       <= '0;
            ready     <= 1'b1;
            pkt_valid <= 1'b0;
            dout      <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef ROUTER_PKT_TX_PARITY_CORRUPT_EN
            corrupt_q <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            state     <= HEADER;
                            dout      <= header;
                            pkt_valid <= 1'b1;
                            par       <= header;
                            cnt       <= pay_len;
                            ready     <= 1'b0;
`ifdef ROUTER_PKT_TX_PARITY_CORRUPT_EN
                            corrupt_q <= corrupt;
`endif
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                HEADER, PAYLOAD: begin
                    if (pay_rd) begin
                        dout  <= pay_in;
                        par   <= par ^ pay_in;
                        cnt   <= cnt - 1'b1;
                        state <= PAYLOAD;
                    end else if (state == PAYLOAD && cnt == '0 && !busy) begin
                        // par already folds in the last payload byte
                        dout      <= par_out;
                        pkt_valid <= 1'b0;
                        state     <= PARITY;
                    end
                end
                PARITY: begin
                    if (!busy) begin
                        state <= DONE;
                        dout  <= '0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Scoreboard bench for router_pkt_tx: expected stream bytes queued at request time, popped on acceptance.
module tb_router_pkt_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] dest_addr;
    logic [5:0] pay_len;
    logic [7:0] pay_in;
    logic       busy;
    logic       ready, pay_rd, pkt_valid, done, err;
    logic [7:0] dout;
`ifdef ROUTER_PKT_TX_PARITY_CORRUPT_EN
    logic       corrupt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int rd_cnt  = 0;
    int pay_base = 0;
    int done_cnt = 0;
    int exp_done = 0;
    bit in_pkt = 0;
    logic [7:0] pay_mem [64];
    logic [8:0] exp_q [$];

    always #5 clk = ~clk;

    router_pkt_tx dut (
        .clk(clk), .rst(rst), .start(start), .dest_addr(dest_addr), .pay_len(pay_len),
        .pay_in(pay_in), .busy(busy),
`ifdef ROUTER_PKT_TX_PARITY_CORRUPT_EN
        .corrupt(corrupt),
`endif
        .ready(ready), .pay_rd(pay_rd), .pkt_valid(pkt_valid), .dout(dout),
        .done(done), .err(err)
    );

    // show-ahead payload source
    assign pay_in = pay_mem[6'(rd_cnt - pay_base)];
    always @(posedge clk) if (pay_rd) rd_cnt <= rd_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // acceptance monitor: a byte is taken at the edge following a negedge with busy=0
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst) begin
            in_pkt = 0;
        end else begin
            if (done) done_cnt++;
            if (busy && (pkt_valid || in_pkt)) chk("pay_rd_while_busy", pay_rd, 0);
            if (!busy && (pkt_valid || in_pkt)) begin
                if (exp_q.size() == 0) chk("unexpected_byte", {pkt_valid, dout}, 9'h1ff);
                else begin
                    e = exp_q.pop_front();
                    chk("stream_byte", {pkt_valid, dout}, e);
                end
                in_pkt = pkt_valid;
            end
        end
    end

    task automatic send_pkt(input logic [1:0] d, input logic [5:0] l, input logic corr,
                            input int stall_at, input int stall_n, input int rst_at);
        logic [7:0] hdr, p;
        int  base;
        bit  got_done;
        hdr = {l, d};
        p   = hdr;
        exp_q.push_back({1'b1, hdr});
        for (int i = 0; i < int'(l); i++) begin
            exp_q.push_back({1'b1, pay_mem[i]});
            p ^= pay_mem[i];
        end
        if (corr) p = ~p;
        exp_q.push_back({1'b0, p});
        exp_done++;
        for (int w = 0; w < 10 && !ready; w++) begin @(posedge clk); #1; end
        chk("ready_before_start", ready, 1);
        base     = rd_cnt;
        pay_base = rd_cnt;
        start = 1'b1; dest_addr = d; pay_len = l;
`ifdef ROUTER_PKT_TX_PARITY_CORRUPT_EN
        corrupt = corr;
`endif
        @(posedge clk); #1;
        // scramble request inputs to prove they were captured
        start = 1'b0; dest_addr = 2'($urandom); pay_len = 6'($urandom);
`ifdef ROUTER_PKT_TX_PARITY_CORRUPT_EN
        corrupt = ~corr;
`endif
        chk("header_latency", {pkt_valid, dout}, {1'b1, hdr});
        chk("ready_low", ready, 0);
        got_done = 0;
        for (int k = 0; k < 400 && !got_done; k++) begin
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_pkt_valid", pkt_valid, 0);
                chk("rst_dout", dout, 0);
                chk("rst_ready", ready, 1);
                chk("rst_done", done, 0);
                exp_q.delete();
                exp_done--;
                @(posedge clk); #1;
                rst  = 1'b0;
                busy = 1'b0;
                return;
            end
            busy = (k >= stall_at) && (k < stall_at + stall_n);
            @(posedge clk); #1;
            if (done) got_done = 1;
        end
        busy = 1'b0;
        chk("done_seen", got_done, 1);
        if (!got_done) exp_q.delete();
        chk("pay_rd_count", rd_cnt - base, l);
        chk("scoreboard_drained", exp_q.size(), 0);
        @(posedge clk); #1;
        chk("ready_after_done", ready, 1);
        chk("done_one_cycle", done, 0);
    endtask

    task automatic send_bad(input logic [1:0] d, input logic [5:0] l);
        start = 1'b1; dest_addr = d; pay_len = l;
        @(posedge clk); #1;
        start = 1'b0;
        chk("bad_err", err, 1);
        chk("bad_ready", ready, 1);
        chk("bad_pkt_valid", pkt_valid, 0);
        @(posedge clk); #1;
        chk("bad_err_pulse", err, 0);
        chk("bad_still_idle", {ready, pkt_valid}, 2'b10);
    endtask

    initial begin
        logic [7:0] nom [3];
        nom = '{8'hA1, 8'h5C, 8'h0F};
        rst = 1'b1; start = 1'b0; dest_addr = '0; pay_len = '0; busy = 1'b0;
`ifdef ROUTER_PKT_TX_PARITY_CORRUPT_EN
        corrupt = 1'b0;
`endif
        for (int i = 0; i < 64; i++) pay_mem[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {ready, pkt_valid, dout, done, err, pay_rd}, {1'b1, 1'b0, 8'h00, 3'b000});
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 3; i++) pay_mem[i] = nom[i];
        send_pkt(2'd1, 6'd3, 1'b0, 0, 0, -1);
        send_pkt(2'd1, 6'd3, 1'b0, 2, 2, -1);

        send_bad(2'd3, 6'd5);
        send_bad(2'd0, 6'd0);

        for (int i = 0; i < 63; i++) pay_mem[i] = 8'(i + 1);
        send_pkt(2'd2, 6'd63, 1'b0, 0, 0, -1);

        for (int i = 0; i < 5; i++) pay_mem[i] = 8'($urandom);
        send_pkt(2'd0, 6'd5, 1'b0, 0, 0, 3);
        chk("no_done_after_rst", done_cnt, exp_done);
        send_pkt(2'd0, 6'd5, 1'b0, 0, 0, -1);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 64; i++) pay_mem[i] = 8'($urandom);
            send_pkt(2'($urandom_range(0, 2)), 6'($urandom_range(1, 63)), 1'b0,
                     $urandom_range(0, 20), $urandom_range(0, 4), -1);
        end

`ifdef ROUTER_PKT_TX_PARITY_CORRUPT_EN
        for (int i = 0; i < 3; i++) pay_mem[i] = nom[i];
        send_pkt(2'd1, 6'd3, 1'b1, 0, 0, -1);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("done_count", done_cnt, exp_done);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
